// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial frame receiver (start, DATA_W data, parity, stop) with parity/framing checks; PARITY_ERR_CNT_EN adds a saturating error counter
module parity_frame_rx #(
    parameter int DATA_W     = 4,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_bit,
    input  logic              in_valid,
`ifdef PARITY_ERR_CNT_EN
    input  logic              cnt_clr,
    output logic [7:0]        out_err_cnt,
`endif
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_perr,
    output logic              out_ferr,
    output logic              out_busy
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam logic ODD = 1'(ODD_PARITY);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [CW-1:0]     bitCnt;
    logic [DATA_W-1:0] shiftReg;
    logic              acc;
    logic              frameDone;
    logic              perrNext;
    logic              ferrNext;

    assign frameDone = in_valid && (state == STOP);
    assign perrNext  = acc != ODD;
    assign ferrNext  = ~in_bit;
    assign out_busy  = state != IDLE;

    // Frame FSM: advances only on qualified bits, publishes the word at the stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bitCnt    <= '0;
            shiftReg  <= '0;
            acc       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_perr  <= 1'b0;
            out_ferr  <= 1'b0;
        end else begin
            out_valid <= frameDone;
            if (frameDone) begin
                out_data <= shiftReg;
                out_perr <= perrNext;
                out_ferr <= ferrNext;
            end
            if (in_valid) begin
                case (state)
                    IDLE: if (!in_bit) begin
                        state  <= DATA;
                        bitCnt <= '0;
                        acc    <= 1'b0;
                    end
                    DATA: begin
                        shiftReg <= {shiftReg[DATA_W-2:0], in_bit};
                        acc      <= acc ^ in_bit;
                        bitCnt   <= bitCnt + 1'b1;
                        if (bitCnt == LAST) state <= PARITY;
                    end
                    PARITY: begin
                        acc   <= acc ^ in_bit;
                        state <= STOP;
                    end
                    STOP: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    // Saturating count of errored frames, updated alongside the published flags; clear wins
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) out_err_cnt <= 8'h00;
        else if (frameDone && (perrNext || ferrNext) && out_err_cnt != 8'hFF) out_err_cnt <= out_err_cnt + 8'h01;
    end
`endif
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: table-driven and scoreboard bench for parity_frame_rx
module tb_parity_frame_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_perr;
    logic       out_ferr;
    logic       out_busy;
`ifdef PARITY_ERR_CNT_EN
    logic       cnt_clr = 1'b0;
    logic [7:0] out_err_cnt;
`endif

    typedef struct {
        logic [3:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [6:0] bits;
        int         gap;
        logic [3:0] data;
        logic       perr;
        logic       ferr;
    } vec_t;

    exp_t q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    parity_frame_rx #(.DATA_W(4), .ODD_PARITY(0)) dut (
        .clk(clk),
        .rst(rst),
        .in_bit(in_bit),
        .in_valid(in_valid),
`ifdef PARITY_ERR_CNT_EN
        .cnt_clr(cnt_clr),
        .out_err_cnt(out_err_cnt),
`endif
        .out_data(out_data),
        .out_valid(out_valid),
        .out_perr(out_perr),
        .out_ferr(out_ferr),
        .out_busy(out_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (out_valid) begin
            pulses++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid: got pulse with data %0h expected none", out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_perr", 32'(out_perr), 32'(e.perr));
                chk("out_ferr", 32'(out_ferr), 32'(e.ferr));
            end
        end
    end

    task automatic sendBit(input logic b, input int gap);
        in_valid = 1'b1;
        in_bit = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_bit = ~in_bit;
            @(posedge clk); #1;
        end
    endtask

    task automatic sendFrame(input logic [6:0] bits, input int gap, input logic [3:0] d, input logic pe, input logic fe);
        for (int i = 6; i >= 0; i--) begin
            if (i == 0) q.push_back('{data: d, perr: pe, ferr: fe});
            sendBit(bits[i], (i == 0) ? 0 : gap);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        vecs[0] = '{bits: 7'b0101111, gap: 0, data: 4'b1011, perr: 1'b0, ferr: 1'b0};
        vecs[1] = '{bits: 7'b0101101, gap: 0, data: 4'b1011, perr: 1'b1, ferr: 1'b0};
        vecs[2] = '{bits: 7'b0011000, gap: 0, data: 4'b0110, perr: 1'b0, ferr: 1'b1};
        vecs[3] = '{bits: 7'b0111101, gap: 3, data: 4'b1111, perr: 1'b0, ferr: 1'b0};
        vecs[4] = '{bits: 7'b0101111, gap: 0, data: 4'b1011, perr: 1'b0, ferr: 1'b0};
        vecs[5] = '{bits: 7'b0000001, gap: 0, data: 4'b0000, perr: 1'b0, ferr: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_data", 32'(out_data), 0);
        chk("reset_perr", 32'(out_perr), 0);
        chk("reset_ferr", 32'(out_ferr), 0);
        chk("reset_busy", 32'(out_busy), 0);
        rst = 1'b0;
        idle(1);

        sendFrame(7'b0101111, 0, 4'b1011, 1'b0, 1'b0);
        idle(2);
        chk("hold_valid", 32'(out_valid), 0);
        chk("hold_data", 32'(out_data), 32'h0000000b);
        chk("hold_busy", 32'(out_busy), 0);

        sendBit(1'b0, 0);
        sendBit(1'b1, 0);
        sendBit(1'b1, 0);
        chk("midframe_busy", 32'(out_busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(out_busy), 0);
        chk("abort_data", 32'(out_data), 0);
        sendFrame(7'b0000111, 0, 4'b0001, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 6; i++) sendFrame(vecs[i].bits, vecs[i].gap, vecs[i].data, vecs[i].perr, vecs[i].ferr);
        repeat (3) sendBit(1'b1, 0);
        chk("idle_ones_busy", 32'(out_busy), 0);

        for (int n = 0; n < 20; n++) begin
            logic [3:0] d;
            logic p, s;
            d = 4'($urandom_range(0, 15));
            p = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            sendFrame({1'b0, d, p, s}, $urandom_range(0, 2), d, ^{d, p}, ~s);
        end
        idle(2);

`ifdef PARITY_ERR_CNT_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("cnt_reset", 32'(out_err_cnt), 0);
        sendFrame(7'b0101101, 0, 4'b1011, 1'b1, 1'b0);
        idle(1);
        chk("cnt_one", 32'(out_err_cnt), 1);
        for (int n = 0; n < 300; n++) sendFrame(7'b0000011, 0, 4'b0000, 1'b1, 1'b0);
        idle(1);
        chk("cnt_saturate", 32'(out_err_cnt), 255);
        for (int i = 6; i >= 1; i--) sendBit(vecs[2].bits[i], 0);
        q.push_back('{data: 4'b0110, perr: 1'b0, ferr: 1'b1});
        cnt_clr = 1'b1;
        sendBit(1'b0, 1);
        cnt_clr = 1'b0;
        chk("cnt_clear_wins", 32'(out_err_cnt), 0);
`endif

        for (int t = 0; t < 20 && q.size() != 0; t++) idle(1);
        chk("pending_expectations", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Receive-side checker for the 4-bit even-parity link. Accepts a serial frame: start bit, DATA_W data bits, one parity bit, one stop bit.
- Reassembles the data word, recomputes parity and reports parity and framing errors.
- Sits at the far end of the parity generator path. Delivers one word per frame to downstream logic with a single-cycle valid pulse.

Parameters:
- DATA_W, 4, number of data bits per frame (legal range 2..16).
- ODD_PARITY, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (XOR must be 1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_bit  input  1  serial line bit, sampled only when in_valid=1.
- in_valid  input  1  qualifies in_bit for the current cycle; gaps allowed anywhere in a frame.
- out_data  output  DATA_W  last received word, MSB = first data bit received.
- out_valid  output  1  one-cycle pulse, frame complete.
- out_perr  output  1  parity error for the frame flagged by out_valid.
- out_ferr  output  1  framing error (stop bit = 0) for the frame flagged by out_valid.
- out_busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - out_data=0, out_valid=0, out_perr=0, out_ferr=0, out_busy=0.
  - Bit counter and shift register are cleared.
  - Reset mid-frame discards the partial frame; no valid pulse is issued.
- General rule: all state advances only on cycles with in_valid=1. With in_valid=0 the state, counter and shift register hold.
- IDLE:
  - in_valid=1 and in_bit=0 (start bit) -> DATA, counter=0.
  - in_bit=1 in IDLE is line idle and is ignored.
- DATA:
  - Each valid bit is shifted in LSB-side: shift = {shift[DATA_W-2:0], in_bit}, so the first bit lands at the MSB.
  - Running parity accumulator is XORed with in_bit.
  - After DATA_W valid bits -> PARITY.
- PARITY:
  - The valid bit is captured into the parity accumulator -> STOP.
- STOP, on a valid bit:
  - out_data <= shift.
  - out_perr <= (acc != ODD_PARITY).
  - out_ferr <= ~in_bit.
  - out_valid=1 for exactly that next cycle.
  - State -> IDLE.
- Latency: out_valid and updated out_data/flags are visible in the cycle after the clock edge that samples the stop bit.
- Frame length is fixed at 1+DATA_W+2 valid bits.
- out_data, out_perr and out_ferr hold their values until the next completed frame; they are not cleared when out_valid drops.
- out_valid pulses even when out_perr or out_ferr is set. Downstream decides whether to drop the word.
- Back-to-back frames: a start bit on the cycle immediately after the stop bit is accepted. The IDLE transition happens at the stop edge, so no dead cycle is required.
- Framing error does not trigger resynchronisation beyond returning to IDLE. The next 0 seen in IDLE is treated as a start bit.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined:
  - Adds output out_err_cnt, 8 bits.
  - Increments by 1 on each out_valid with out_perr=1 or out_ferr=1 (either flag counts once per frame).
  - Saturates at 8'hFF.
  - Cleared to 0 by rst.
  - Adds input cnt_clr (1 bit): synchronous clear. If cnt_clr and an increment coincide, the clear wins and the result is 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then valid bits 0,1,0,1,1,1,1 (start, data 1011, parity 1, stop) -> one cycle after the stop bit: out_valid=1, out_data=4'b1011, out_perr=0, out_ferr=0. Then out_valid=0 and out_data holds 1011.
2. Frame 0,1,0,1,1,0,1 (parity wrong) -> out_valid=1, out_data=4'b1011, out_perr=1, out_ferr=0. With PARITY_ERR_CNT_EN: out_err_cnt=1.
3. Frame 0,0,1,1,0,0,0 (stop=0) -> out_valid=1, out_data=4'b0110, out_perr=0, out_ferr=1.
4. Frame 0,1,1,1,1,0,1 with in_valid=0 for 3 cycles between every bit, and in_bit toggling during the gaps -> out_data=4'b1111, no errors, exactly one out_valid pulse.
5. Start a frame, rst=1 after 2 data bits, then send a full frame 0,0,0,0,1,1,1 -> no pulse for the aborted frame; one pulse with out_data=4'b0001, out_perr=0.
6. Two frames back-to-back with no idle bits (1011/p1, then 0000/p0), plus 300 errored frames with PARITY_ERR_CNT_EN -> two consecutive valid pulses with the correct words; out_err_cnt saturates at 255. cnt_clr asserted in the same cycle as an error frame's valid pulse -> out_err_cnt=0.
